// File: rtl/ide_mdma_seq_if.sv
// rtl/ide_mdma_seq_if.sv - drive handshake, Port A and status signals of the multiword-DMA sequencer
interface ide_mdma_seq_if;
  logic        DMA_ARM;
  logic        PS2WrIDE;
  logic [7:0]  XFER_SECT;
  logic        DMARQ;
  logic        DMACK_n;
  logic        DIOR_n;
  logic        DIOW_n;
  logic [15:0] DD_IN;
  logic [15:0] DD_OUT;
  logic        DD_OE;
  logic [15:0] DInA;
  logic [15:0] DOutA;
  logic        EnbA;
  logic        WrA;
  logic        RegEA;
  logic        IncAddrA;
  logic        HWOE;
  logic        A0;
  logic        WithinABlock;
  logic        PA_HvSpace;
  logic        PA_OD_Rdy;
  logic        CRC_ARM;
  logic        CRC_ENB;
  logic        BUSY;
  logic        XFER_DONE;

  modport master (
    input  DMA_ARM, PS2WrIDE, XFER_SECT, DMARQ, DD_IN, DOutA,
           A0, WithinABlock, PA_HvSpace, PA_OD_Rdy,
    output DMACK_n, DIOR_n, DIOW_n, DD_OUT, DD_OE, DInA,
           EnbA, WrA, RegEA, IncAddrA, HWOE, CRC_ARM, CRC_ENB, BUSY, XFER_DONE
  );

  modport slave (
    output DMA_ARM, PS2WrIDE, XFER_SECT, DMARQ, DD_IN, DOutA,
           A0, WithinABlock, PA_HvSpace, PA_OD_Rdy,
    input  DMACK_n, DIOR_n, DIOW_n, DD_OUT, DD_OE, DInA,
           EnbA, WrA, RegEA, IncAddrA, HWOE, CRC_ARM, CRC_ENB, BUSY, XFER_DONE
  );
endinterface

// File: rtl/ide_mdma_seq.sv
// rtl/ide_mdma_seq.sv - IDE multiword-DMA sequencer between drive bus and buffer Port A
// Optional CRC unit controls are built when IDE_CRC_EN is defined.
module ide_mdma_seq #(
  parameter int T_ACT = 4,
  parameter int T_REC = 2
) (
  input  logic          CLK4,
  input  logic          RST,
  ide_mdma_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_GATE, S_PREF0, S_PREF1, S_PREF2, S_ACK, S_STRB, S_REC, S_PAUSE, S_DONE
  } state_t;

  localparam logic [7:0] ACT_LAST = 8'(T_ACT - 1);
  localparam logic [7:0] REC_LAST = 8'(T_REC - 1);

  state_t      state_q, state_d;
  logic [1:0]  rq_sync_q;
  logic        rq;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  tmr_q, tmr_d;
  logic        wr_dir_q, wr_dir_d;
  logic        gate_ok, rd_last;

  logic        dmack_n_q, dmack_n_d;
  logic        dior_n_q, dior_n_d;
  logic        diow_n_q, diow_n_d;
  logic        dd_oe_q, dd_oe_d;
  logic [15:0] dd_out_q, dina_q;
  logic        enba_q, enba_d, wra_q, wra_d, rega_q, rega_d, inc_q, inc_d;
  logic        hwoe_q, busy_q, busy_d, done_q, done_d;

  assign rq = rq_sync_q[1];

  always_ff @(posedge CLK4) begin
    if (RST) rq_sync_q <= 2'b00;
    else     rq_sync_q <= {rq_sync_q[0], bus.DMARQ};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    wr_dir_d = wr_dir_q;
    gate_ok  = bus.WithinABlock | (wr_dir_q ? bus.PA_OD_Rdy : bus.PA_HvSpace);
    rd_last  = (state_q == S_STRB) && (tmr_q == 8'd0) && !wr_dir_q;
    unique case (state_q)
      S_IDLE: if (rq) begin
        state_d  = S_GATE;
        cnt_d    = (bus.XFER_SECT == 8'd0) ? 17'h10000 : {1'b0, bus.XFER_SECT, 8'h00};
        wr_dir_d = bus.PS2WrIDE;
      end
      S_GATE:  if (gate_ok) state_d = wr_dir_q ? S_PREF0 : S_ACK;
      S_PREF0: state_d = S_PREF1;
      S_PREF1: state_d = S_PREF2;
      S_PREF2: state_d = S_ACK;
      S_ACK: begin
        state_d = S_STRB;
        tmr_d   = ACT_LAST;
      end
      S_STRB: if (tmr_q == 8'd0) begin
        state_d = S_REC;
        tmr_d   = REC_LAST;
        cnt_d   = cnt_q - 17'd1;
      end else begin
        tmr_d = tmr_q - 8'd1;
      end
      S_REC: if (tmr_q != 8'd0)     tmr_d   = tmr_q - 8'd1;
             else if (cnt_q == '0)  state_d = S_DONE;
             else if (!rq)          state_d = S_PAUSE;
             else                   state_d = S_GATE;
      S_PAUSE: if (rq) state_d = S_GATE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // DMACK stays asserted through stalls and prefetch between words, but not after a pause
    dmack_n_d = !((state_d inside {S_ACK, S_STRB, S_REC}) ||
                  (!dmack_n_q && (state_d inside {S_GATE, S_PREF0, S_PREF1, S_PREF2})));
    dior_n_d  = !((state_d == S_STRB) && !wr_dir_d);
    diow_n_d  = !((state_d == S_STRB) && wr_dir_d);
    dd_oe_d   = wr_dir_d && !dmack_n_d;
    wra_d     = rd_last;
    enba_d    = rd_last || (state_d == S_PREF0);
    inc_d     = rd_last || (state_d == S_PREF2);
    rega_d    = (state_d == S_PREF1);
    busy_d    = !(state_d inside {S_IDLE, S_DONE});
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK4) begin
    if (RST || !bus.DMA_ARM) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      wr_dir_q  <= 1'b0;
      dmack_n_q <= 1'b1;
      dior_n_q  <= 1'b1;
      diow_n_q  <= 1'b1;
      dd_oe_q   <= 1'b0;
      dd_out_q  <= '0;
      dina_q    <= '0;
      enba_q    <= 1'b0;
      wra_q     <= 1'b0;
      rega_q    <= 1'b0;
      inc_q     <= 1'b0;
      hwoe_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      wr_dir_q  <= wr_dir_d;
      dmack_n_q <= dmack_n_d;
      dior_n_q  <= dior_n_d;
      diow_n_q  <= diow_n_d;
      dd_oe_q   <= dd_oe_d;
      enba_q    <= enba_d;
      wra_q     <= wra_d;
      rega_q    <= rega_d;
      inc_q     <= inc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (state_q == S_PREF0) hwoe_q   <= bus.A0;
      if (state_q == S_PREF2) dd_out_q <= bus.DOutA;
      if (rd_last)            dina_q   <= bus.DD_IN;
    end
  end

  assign bus.DMACK_n   = dmack_n_q;
  assign bus.DIOR_n    = dior_n_q;
  assign bus.DIOW_n    = diow_n_q;
  assign bus.DD_OE     = dd_oe_q;
  assign bus.DD_OUT    = dd_out_q;
  assign bus.DInA      = dina_q;
  assign bus.EnbA      = enba_q;
  assign bus.WrA       = wra_q;
  assign bus.RegEA     = rega_q;
  assign bus.IncAddrA  = inc_q;
  assign bus.HWOE      = hwoe_q;
  assign bus.BUSY      = busy_q;
  assign bus.XFER_DONE = done_q;

`ifdef IDE_CRC_EN
  logic crc_arm_q, crc_enb_q;

  // ARM is held low during the first cycle out of IDLE so the CRC unit clears
  always_ff @(posedge CLK4) begin
    if (RST || !bus.DMA_ARM) begin
      crc_arm_q <= 1'b0;
      crc_enb_q <= 1'b0;
    end else begin
      crc_arm_q <= !(state_d inside {S_IDLE, S_DONE}) && (state_q != S_IDLE);
      crc_enb_q <= rd_last || (state_d == S_PREF2);
    end
  end

  assign bus.CRC_ARM = crc_arm_q;
  assign bus.CRC_ENB = crc_enb_q;
`else
  assign bus.CRC_ARM = 1'b0;
  assign bus.CRC_ENB = 1'b0;
`endif

endmodule

// File: tb/tb_ide_mdma_seq.sv
// tb/tb_ide_mdma_seq.sv - directed bench for the IDE multiword-DMA sequencer
module tb_ide_mdma_seq;

`ifdef IDE_CRC_EN
  localparam int EXP_CRC = 256;
`else
  localparam int EXP_CRC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  int   total = 0;
  int   bad = 0;

  int   nstrb, nwstrb, nwr, ncrc, nfall, ncyc, t0, t1;
  int   rd_err, wr_err, pulse_err, crc_err;
  logic p_dior, p_diow, p_wra, p_enba, p_inc;
  logic [16:0] addr;

  ide_mdma_seq_if bus ();

  ide_mdma_seq #(.T_ACT(4), .T_REC(2)) dut (
    .CLK4 (clk),
    .RST  (rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rdpat(input int i);
    return 16'((i * 37) + 23040);
  endfunction

  function automatic logic [15:0] wpat(input int i);
    return 16'((i * 113) + 3120);
  endfunction

  assign bus.DD_IN        = rdpat(nstrb - 1);
  assign bus.DOutA        = wpat(int'(addr));
  assign bus.A0           = addr[0];
  assign bus.WithinABlock = (addr[7:0] != 8'd0);

  always @(posedge clk) begin
    if (clr)               addr <= '0;
    else if (bus.IncAddrA) addr <= addr + 17'd1;
  end

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (clr) begin
      nstrb <= 0; nwstrb <= 0; nwr <= 0; ncrc <= 0; nfall <= 0; t0 <= 0; t1 <= 0;
      rd_err <= 0; wr_err <= 0; pulse_err <= 0; crc_err <= 0;
      p_dior <= 1'b1; p_diow <= 1'b1; p_wra <= 1'b0; p_enba <= 1'b0; p_inc <= 1'b0;
    end else begin
      if (!bus.DIOR_n && p_dior) nstrb <= nstrb + 1;
      if (!bus.DIOW_n && p_diow) begin
        nwstrb <= nwstrb + 1;
        if (bus.DD_OUT !== wpat(nwstrb) || bus.DD_OE !== 1'b1) wr_err <= wr_err + 1;
      end
      if (bus.DIOW_n && !p_diow && bus.DD_OUT !== wpat(nwstrb - 1)) wr_err <= wr_err + 1;
      if ((!bus.DIOR_n && p_dior) || (!bus.DIOW_n && p_diow)) begin
        if (nfall == 0) t0 <= ncyc;
        if (nfall == 1) t1 <= ncyc;
        nfall <= nfall + 1;
      end
      if (bus.WrA) begin
        nwr <= nwr + 1;
        if (bus.DInA !== rdpat(nwr) || !bus.EnbA || !bus.IncAddrA) rd_err <= rd_err + 1;
      end
      if ((bus.WrA && p_wra) || (bus.EnbA && p_enba) || (bus.IncAddrA && p_inc))
        pulse_err <= pulse_err + 1;
      if (bus.CRC_ENB) ncrc <= ncrc + 1;
`ifdef IDE_CRC_EN
      if (bus.CRC_ENB && !bus.WrA && !bus.IncAddrA) crc_err <= crc_err + 1;
`else
      if (bus.CRC_ENB || bus.CRC_ARM) crc_err <= crc_err + 1;
`endif
      p_dior <= bus.DIOR_n; p_diow <= bus.DIOW_n;
      p_wra <= bus.WrA; p_enba <= bus.EnbA; p_inc <= bus.IncAddrA;
    end
  end

  task automatic start_xfer(input logic dir, input logic [7:0] sect);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    bus.PS2WrIDE  = dir;
    bus.XFER_SECT = sect;
    bus.DMARQ     = 1'b1;
    bus.DMA_ARM   = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while (!bus.XFER_DONE && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    logic [11:0] got;
    bus.DMA_ARM = 1'b0; bus.PS2WrIDE = 1'b0; bus.XFER_SECT = 8'd1; bus.DMARQ = 1'b0;
    bus.PA_HvSpace = 1'b0; bus.PA_OD_Rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {bus.DMACK_n, bus.DIOR_n, bus.DIOW_n, bus.DD_OE, bus.EnbA, bus.WrA, bus.RegEA,
           bus.IncAddrA, bus.HWOE, bus.CRC_ARM | bus.CRC_ENB, bus.BUSY, bus.XFER_DONE};
    total++;
    if (got !== 12'b1110_0000_0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 111000000000", got);
    end
    total++;
    if (bus.DD_OUT !== 16'h0 || bus.DInA !== 16'h0) begin
      bad++; $display("FAIL reset_data: got DD_OUT=%h DInA=%h want 0", bus.DD_OUT, bus.DInA);
    end
    rst = 1'b0;
    bus.DMARQ = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (bus.BUSY !== 1'b0 || bus.DMACK_n !== 1'b1) begin
      bad++; $display("FAIL disarmed_idle: got BUSY=%b DMACK_n=%b want 0/1", bus.BUSY, bus.DMACK_n);
    end
    bus.DMARQ = 1'b0;
  endtask

  task automatic test_read;
    bus.PA_HvSpace = 1'b1;
    start_xfer(1'b0, 8'd1);
    wait_done(4000);
    total++;
    if (bus.XFER_DONE !== 1'b1) begin
      bad++; $display("FAIL read_done: got %b want 1", bus.XFER_DONE);
    end
    total++;
    if (nstrb !== 256 || nwr !== 256) begin
      bad++; $display("FAIL read_count: got strobes=%0d writes=%0d want 256/256", nstrb, nwr);
    end
    total++;
    if (rd_err !== 0 || pulse_err !== 0) begin
      bad++; $display("FAIL read_data: got data_err=%0d pulse_err=%0d want 0/0", rd_err, pulse_err);
    end
    total++;
    if (t1 - t0 !== 8) begin
      bad++; $display("FAIL read_word_time: got %0d want 8", t1 - t0);
    end
    total++;
    if (bus.DMACK_n !== 1'b1 || bus.BUSY !== 1'b0 || bus.DD_OE !== 1'b0) begin
      bad++; $display("FAIL read_end: got DMACK_n=%b BUSY=%b DD_OE=%b want 1/0/0",
                      bus.DMACK_n, bus.BUSY, bus.DD_OE);
    end
    total++;
    if (ncrc !== EXP_CRC || crc_err !== 0) begin
      bad++; $display("FAIL read_crc: got pulses=%0d err=%0d want %0d/0", ncrc, crc_err, EXP_CRC);
    end
    bus.DMA_ARM = 1'b0;
    @(negedge clk);
    total++;
    if (bus.XFER_DONE !== 1'b0) begin
      bad++; $display("FAIL done_release: got %b want 0", bus.XFER_DONE);
    end
  endtask

  task automatic test_write_stall;
    int cyc;
    bus.PA_HvSpace = 1'b0;
    bus.PA_OD_Rdy  = 1'b1;
    start_xfer(1'b1, 8'd2);
    cyc = 0;
    while (nwstrb < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    bus.PA_OD_Rdy = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (nwstrb !== 256 || bus.DMACK_n !== 1'b0 || bus.DIOW_n !== 1'b1 || bus.BUSY !== 1'b1) begin
      bad++; $display("FAIL write_stall: got strobes=%0d DMACK_n=%b DIOW_n=%b BUSY=%b want 256/0/1/1",
                      nwstrb, bus.DMACK_n, bus.DIOW_n, bus.BUSY);
    end
    bus.PA_OD_Rdy = 1'b1;
    wait_done(4000);
    total++;
    if (bus.XFER_DONE !== 1'b1 || nwstrb !== 512) begin
      bad++; $display("FAIL write_done: got done=%b strobes=%0d want 1/512", bus.XFER_DONE, nwstrb);
    end
    total++;
    if (wr_err !== 0 || pulse_err !== 0 || bus.DD_OE !== 1'b0) begin
      bad++; $display("FAIL write_data: got data_err=%0d pulse_err=%0d DD_OE=%b want 0/0/0",
                      wr_err, pulse_err, bus.DD_OE);
    end
    total++;
    if (t1 - t0 !== 11) begin
      bad++; $display("FAIL write_word_time: got %0d want 11", t1 - t0);
    end
    bus.DMA_ARM = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pause;
    int cyc;
    int low_cnt;
    bus.PA_HvSpace = 1'b1;
    start_xfer(1'b0, 8'd1);
    cyc = 0;
    while (nstrb < 10 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    bus.DMARQ = 1'b0;
    cyc = 0;
    while (bus.DMACK_n !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    low_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.DMACK_n !== 1'b1) low_cnt++;
    end
    total++;
    if (low_cnt !== 0 || nstrb !== 10 || nwr !== 10) begin
      bad++; $display("FAIL pause_gap: got dmack_low=%0d strobes=%0d writes=%0d want 0/10/10",
                      low_cnt, nstrb, nwr);
    end
    bus.DMARQ = 1'b1;
    wait_done(4000);
    total++;
    if (bus.XFER_DONE !== 1'b1 || nwr - 10 !== 246 || rd_err !== 0) begin
      bad++; $display("FAIL pause_resume: got done=%b after=%0d err=%0d want 1/246/0",
                      bus.XFER_DONE, nwr - 10, rd_err);
    end
    bus.DMA_ARM = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int cyc;
    bus.PA_HvSpace = 1'b1;
    start_xfer(1'b0, 8'd1);
    cyc = 0;
    while (nstrb < 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.DMA_ARM = 1'b0;
    @(negedge clk);
    total++;
    if (bus.DIOR_n !== 1'b1 || bus.DMACK_n !== 1'b1 || bus.BUSY !== 1'b0) begin
      bad++; $display("FAIL abort_now: got DIOR_n=%b DMACK_n=%b BUSY=%b want 1/1/0",
                      bus.DIOR_n, bus.DMACK_n, bus.BUSY);
    end
    repeat (5) @(negedge clk);
    total++;
    if (nwr !== 0 || bus.DInA !== 16'h0 || nstrb !== 1) begin
      bad++; $display("FAIL abort_nowrite: got writes=%0d DInA=%h strobes=%0d want 0/0000/1",
                      nwr, bus.DInA, nstrb);
    end
  endtask

  task automatic test_sect_zero;
    int cyc;
    bus.PA_HvSpace = 1'b1;
    start_xfer(1'b0, 8'd0);
    cyc = 0;
    while (nstrb < 300 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (nstrb < 300 || bus.XFER_DONE !== 1'b0 || bus.BUSY !== 1'b1 || rd_err !== 0) begin
      bad++; $display("FAIL sect_zero: got strobes=%0d done=%b BUSY=%b err=%0d want >=300/0/1/0",
                      nstrb, bus.XFER_DONE, bus.BUSY, rd_err);
    end
    bus.DMA_ARM = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_pause();
    test_abort();
    test_sect_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ide_mdma_seq.md
# ide_mdma_seq

Multiword-DMA sequencer for the IDE side of the adaptor. It drives the drive's DMACK/DIOR/DIOW handshake and moves 16-bit words between the drive data bus and Port A of the dual-port DMA buffer, one word per strobe. It sits directly upstream of the buffer on drive-to-PS2 transfers and directly downstream of it on PS2-to-drive transfers. It gates each 256-word (512-byte) block on the buffer's page-space and data-ready flags.

## Interface
Parameters:
- T_ACT, 4: DIOR_n/DIOW_n low time in CLK4 cycles (≥2).
- T_REC, 2: strobe-high recovery time in CLK4 cycles (≥1).

Ports:
- CLK4  in  1  system clock; every register is clocked on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- DMA_ARM  in  1  low: abort and hold IDLE; high: transfer permitted.
- PS2WrIDE  in  1  1 = buffer→drive (write), 0 = drive→buffer (read); sampled on leaving IDLE.
- XFER_SECT  in  8  sector count, sampled on leaving IDLE; 0 means 256.
- DMARQ  in  1  drive request, asynchronous.
- DMACK_n, DIOR_n, DIOW_n  out  1  drive handshake, active-low.
- DD_IN  in  16  drive data bus (input).
- DD_OUT  out  16  drive data bus (output register).
- DD_OE  out  1  bus output enable.
- DInA  out  16  write data to Port A.
- DOutA  in  16  read data from Port A.
- EnbA, WrA, RegEA, IncAddrA, HWOE  out  1  Port A controls.
- A0, WithinABlock, PA_HvSpace, PA_OD_Rdy  in  1  Port A status.
- CRC_ARM, CRC_ENB  out  1  CRC unit controls.
- BUSY  out  1  high outside IDLE and DONE.
- XFER_DONE  out  1  high while in DONE.

## Operation
- DMARQ passes through a 2-flop synchroniser; only the synchronised value (rq) is used.
- Word counter: 17 bits, loaded with XFER_SECT×256 (65536 when XFER_SECT=0), decremented once per completed strobe.
- States:
  - IDLE: leave when DMA_ARM=1 and rq=1; load the counter; go to GATE.
  - GATE: test the buffer; go to ACK, or to PREF when writing.
    - The test applies only when WithinABlock=0.
    - Read needs PA_HvSpace=1; write needs PA_OD_Rdy=1.
    - While WithinABlock=1 the test passes unconditionally.
  - PREF (write only), 3 cycles:
    - c0: EnbA=1, HWOE latched from A0.
    - c1: RegEA=1.
    - c2: DD_OUT←DOutA; IncAddrA=1.
  - ACK: DMACK_n=0 for 1 cycle of setup. When writing, DD_OE=1 from this state until the counter reaches 0 or the block leaves the transfer.
  - STRB: DIOR_n=0 (read) or DIOW_n=0 (write) for T_ACT cycles.
    - On the last cycle of a read: DInA←DD_IN, and EnbA=WrA=IncAddrA=1 in the following cycle.
  - REC: strobes high for T_REC cycles; counter decrements on entry. On the last REC cycle:
    - counter=0 → DONE.
    - rq=0 → IDLE-PAUSE: DMACK_n=1, then back to GATE on rq=1, keeping the counter.
    - otherwise → GATE.
  - DONE: DMACK_n=1, DD_OE=0, XFER_DONE=1; stay until DMA_ARM=0.
- Stall: if GATE fails, DMACK_n stays asserted with strobes high, and the test repeats every cycle.
- Abort: DMA_ARM=0 or RST=1 in any state takes effect next edge.
  - State returns to IDLE; every output takes its reset value.
  - A half-finished strobe is cut; the word is not written.
- Reset values: DMACK_n=DIOR_n=DIOW_n=1; DD_OUT=DInA=0; DD_OE=0; EnbA=WrA=RegEA=IncAddrA=HWOE=0; CRC_ARM=CRC_ENB=0; BUSY=XFER_DONE=0.

## Timing
- Read, per word: GATE 1 + ACK 1 (first word after GATE) + T_ACT + T_REC cycles.
  - The buffer write lands 1 cycle after DIOR_n rises.
- Write, per word: GATE 1 + PREF 3 + ACK 1 + T_ACT + T_REC cycles.
  - DD_OUT is stable ≥1 cycle before DIOW_n falls and until T_REC ends.
- Control pulses: IncAddrA, WrA, EnbA are single-cycle pulses and never assert in consecutive cycles.
- Synchroniser latency: rq lags DMARQ by 2 cycles. DMARQ deasserting inside STRB completes the current word.
- Block boundary: after the 256th increment of a block, WithinABlock=0, so the next GATE re-tests the buffer flags.
- Simultaneous counter=0 and rq=0 on the last REC cycle: DONE wins.

## Configuration
- IDE_CRC_EN defined:
  - CRC_ARM=1 from leaving IDLE until DONE/abort; it drops to 0 for 1 cycle at transfer start to clear the CRC.
  - CRC_ENB pulses together with WrA on reads, and in PREF c2 on writes.
- Undefined: CRC_ARM and CRC_ENB are tied to 0, and no CRC logic is present.

## Test plan
- Read, XFER_SECT=1, DMARQ held high, PA_HvSpace=1 → 256 DIOR_n pulses, 256 WrA pulses carrying the DD_IN values in order, XFER_DONE=1, DMACK_n=1.
- Write, XFER_SECT=2, PA_OD_Rdy=1 only for the first block → DMACK_n stays low and strobes stop after word 256; after setting PA_OD_Rdy=1, words 257..512 follow with DIOW_n data equal to the buffer contents.
- DMARQ dropped after word 10 and raised 20 cycles later → DMACK_n=1 for the gap; 246 more words are transferred; the total counter reaches 0 exactly.
- DMA_ARM=0 mid-STRB → next cycle DIOR_n=1, DMACK_n=1, BUSY=0, and no WrA for that word.
- XFER_SECT=0 → exactly 65536 strobes before XFER_DONE.
- IDE_CRC_EN defined, read of 256 words → 256 CRC_ENB pulses, each coincident with WrA; undefined → CRC_ARM=CRC_ENB=0 throughout.
